mips_cpu_div: RTL and testbench
===============================

Name: mips_cpu_div

Overview:
Multicycle iterative divider serving the ALU's DIV/DIVU/MOD/MODU ops (ctrl 4'b1100–4'b1111).
- ALU/control path issues a request; this block answers with quotient and remainder after a fixed latency.
- This replaces the single-cycle a/b and a%b path.
- It is the responder end of the divide handshake: start, signdiv, busy, done.

Parameters:
WIDTH, 32, operand/result width in bits.
CNTW, 5, iteration counter width (log2 WIDTH).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request pulse; operands sampled on the edge where start=1 and the block is in IDLE or DONE.
signdiv  in  1  1 = signed (DIV/MOD), 0 = unsigned (DIVU/MODU); sampled with start.
a  in  WIDTH  dividend.
b  in  WIDTH  divisor.
busy  out  1  high in PREP, RUN, FIX.
done  out  1  one-cycle pulse; q/r/divzero valid.
q  out  WIDTH  quotient; held until next accepted start.
r  out  WIDTH  remainder; held until next accepted start.
divzero  out  1  b was zero for the completed op; held with q/r.

Behaviour:
- Reset, synchronous, wins over everything including mid-operation:
  - state = IDLE.
  - busy = 0, done = 0, q = 0, r = 0, divzero = 0.
  - The in-flight op is discarded; no done is produced for it.
- States and transitions:
  - IDLE: start=1 goes to PREP and latches a, b, signdiv.
  - PREP: 1 cycle. Forms magnitudes (two's-complement negate if signdiv and MSB set). Records qneg = sa^sb and rneg = sa. Clears partial remainder and counter. Goes to RUN.
  - RUN: exactly WIDTH cycles of restoring division, MSB-first.
    - Shift {rem, quo} left 1; trial = rem − |b|.
    - If trial is non-negative: rem = trial, quo LSB = 1; else quo LSB = 0.
    - Counter wraps at WIDTH−1; goes to FIX.
  - FIX: 1 cycle. Negates quo if qneg, negates rem if rneg. Registers into q/r/divzero. Goes to DONE.
  - DONE: done=1 for this cycle only.
    - start=1 goes to PREP (back-to-back accepted, new operands latched).
    - Otherwise goes to IDLE.
- Latency: start accepted at edge N; done high in the cycle after edge N+WIDTH+2 (N+34 for WIDTH=32). Throughput is one op per 35 cycles.
- start while busy=1: ignored. Operands are not re-sampled; a/b/signdiv may change freely after the accepting edge.
- Signed semantics: quotient truncates toward zero; remainder takes the dividend's sign; |r| < |b|.
- Overflow, signed 0x80000000 / 0xFFFFFFFF: q = 0x80000000, r = 0. This falls out of the magnitude datapath with no special case.
- Divide by zero (b=0, either mode):
  - Same latency; divzero = 1.
  - q = 0xFFFFFFFF, r = a (original dividend), regardless of signdiv. The sign fix is bypassed.
- q/r change only in FIX and on reset.

Decomposition:
- Package mips_cpu_div_pkg:
  - state enum div_state_t {IDLE, PREP, RUN, FIX, DONE}.
  - ALU ctrl constants ALU_DIV = 4'b1100, ALU_MOD = 4'b1101, ALU_DIVU = 4'b1110, ALU_MODU = 4'b1111.
  - DIV_LATENCY = WIDTH+2.
- One natural sub-module, mips_cpu_div_step: combinational single restoring iteration. Inputs rem, quo, divisor; outputs next rem, next quo.

Test Plan:
- Unsigned: start, signdiv=0, a=100, b=7 → busy=1 for 34 cycles, done at N+34 with q=14, r=2, divzero=0.
- Signed: a=−7 (0xFFFFFFF9), b=2, signdiv=1 → q=0xFFFFFFFD (−3), r=0xFFFFFFFF (−1). Repeat with a=7, b=−2 → q=−3, r=1.
- Unsigned large: a=0xFFFFFFFF, b=1, signdiv=0 → q=0xFFFFFFFF, r=0. Same operands with signdiv=1 → q=0xFFFFFFFF (−1), r=0.
- Corner cases:
  - Overflow 0x80000000 / 0xFFFFFFFF signed → q=0x80000000, r=0.
  - b=0, a=0x12345678 → q=0xFFFFFFFF, r=0x12345678, divzero=1, same latency.
- Handshake:
  - start re-pulsed mid-RUN with new operands → ignored; original result delivered.
  - start in DONE cycle with a=9, b=4 → accepted; done again 34 cycles later with q=2, r=1.
- reset asserted at cycle 10 of RUN → next cycle busy=0, done=0, q=r=0. No done pulse follows; a new start then completes normally.

Source files
------------

// File: rtl/mips_cpu_div_pkg.sv
// rtl/mips_cpu_div_pkg.sv - shared types and constants for the iterative divider
package mips_cpu_div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_CNTW    = 5;
  localparam int DIV_LATENCY = DIV_WIDTH + 2;

  localparam logic [3:0] ALU_DIV  = 4'b1100;
  localparam logic [3:0] ALU_MOD  = 4'b1101;
  localparam logic [3:0] ALU_DIVU = 4'b1110;
  localparam logic [3:0] ALU_MODU = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    RUN,
    FIX,
    DONE
  } div_state_t;

endpackage

// File: rtl/mips_cpu_div_if.sv
// rtl/mips_cpu_div_if.sv - divide request/response handshake between ALU control and divider
interface mips_cpu_div_if
  import mips_cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);
  logic             start;
  logic             signdiv;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             divzero;

  modport master (
    output start, signdiv, a, b,
    input  busy, done, q, r, divzero
  );

  modport slave (
    input  start, signdiv, a, b,
    output busy, done, q, r, divzero
  );
endinterface

// File: rtl/mips_cpu_div_step.sv
// rtl/mips_cpu_div_step.sv - one restoring-division iteration, MSB-first
module mips_cpu_div_step
  import mips_cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem < divisor keeps the shifted value inside WIDTH+1 bits
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, divisor};
    if (!trial[WIDTH]) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = shifted[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/mips_cpu_div.sv
// rtl/mips_cpu_div.sv - multicycle signed/unsigned divider answering DIV/DIVU/MOD/MODU
module mips_cpu_div
  import mips_cpu_div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNTW  = DIV_CNTW
) (
  input  logic           clk,
  input  logic           reset,
  mips_cpu_div_if.slave  bus
);
  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sd_q, sd_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dzp_q, dzp_d;
  logic [WIDTH-1:0] q_q, q_d, r_q, r_d;
  logic             dz_q, dz_d;
  logic             sa, sb;
  logic [WIDTH-1:0] step_rem, step_quo;

  mips_cpu_div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (step_rem),
    .quo_next (step_quo)
  );

  always_comb begin
    state_d = state_q;
    a_d = a_q;  b_d = b_q;  sd_d = sd_q;
    rem_d = rem_q;  quo_d = quo_q;  dvs_d = dvs_q;  cnt_d = cnt_q;
    qneg_d = qneg_q;  rneg_d = rneg_q;  dzp_d = dzp_q;
    q_d = q_q;  r_d = r_q;  dz_d = dz_q;
    sa = sd_q & a_q[WIDTH-1];
    sb = sd_q & b_q[WIDTH-1];
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          state_d = PREP;
          a_d     = bus.a;
          b_d     = bus.b;
          sd_d    = bus.signdiv;
        end
      end
      PREP: begin
        quo_d   = sa ? -a_q : a_q;
        dvs_d   = sb ? -b_q : b_q;
        rem_d   = '0;
        cnt_d   = '0;
        qneg_d  = sa ^ sb;
        rneg_d  = sa;
        dzp_d   = (b_q == '0);
        state_d = RUN;
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        // divide-by-zero reports the raw dividend and bypasses sign correction
        if (dzp_q) begin
          q_d = '1;
          r_d = a_q;
        end else begin
          q_d = qneg_q ? -quo_q : quo_q;
          r_d = rneg_q ? -rem_q : rem_q;
        end
        dz_d    = dzp_q;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q <= '0;  b_q <= '0;  sd_q <= 1'b0;
      rem_q <= '0;  quo_q <= '0;  dvs_q <= '0;  cnt_q <= '0;
      qneg_q <= 1'b0;  rneg_q <= 1'b0;  dzp_q <= 1'b0;
      q_q <= '0;  r_q <= '0;  dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;  b_q <= b_d;  sd_q <= sd_d;
      rem_q <= rem_d;  quo_q <= quo_d;  dvs_q <= dvs_d;  cnt_q <= cnt_d;
      qneg_q <= qneg_d;  rneg_q <= rneg_d;  dzp_q <= dzp_d;
      q_q <= q_d;  r_q <= r_d;  dz_q <= dz_d;
    end
  end

  assign bus.busy    = (state_q == PREP) || (state_q == RUN) || (state_q == FIX);
  assign bus.done    = (state_q == DONE);
  assign bus.q       = q_q;
  assign bus.r       = r_q;
  assign bus.divzero = dz_q;
endmodule

// File: tb/tb_mips_cpu_div.sv
// tb/tb_mips_cpu_div.sv - directed vectors plus per-cycle comparison against an arithmetic divide model
module tb_mips_cpu_div;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_cpu_div_if #(.WIDTH(32)) bus ();

  mips_cpu_div #(.WIDTH(32), .CNTW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  logic        m_pend = 1'b0;
  int          m_done_cyc = 0;
  logic [64:0] m_res = '0;
  logic [31:0] m_q = '0, m_r = '0;
  logic        m_dz = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [31:0] a, input logic [31:0] b, input logic sd);
    int sa, sb;
    logic [31:0] q, r;
    sa = a;
    sb = b;
    if (b == 32'd0) return {1'b1, 32'hFFFF_FFFF, a};
    if (!sd) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    return {1'b0, q, r};
  endfunction

  // result appears 34 edges after the accepting edge; start while busy is dropped
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_pend <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_dz   <= 1'b0;
    end else begin
      if (m_pend && (cyc + 1 == m_done_cyc)) begin
        m_q  <= m_res[63:32];
        m_r  <= m_res[31:0];
        m_dz <= m_res[64];
      end
      if (bus.start && !(m_pend && cyc < m_done_cyc)) begin
        m_pend     <= 1'b1;
        m_done_cyc <= cyc + 1 + 34;
        m_res      <= model(bus.a, bus.b, bus.signdiv);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'd0, bus.busy}, {31'd0, m_pend && (cyc < m_done_cyc)});
      chk("done", {31'd0, bus.done}, {31'd0, m_pend && (cyc == m_done_cyc)});
      chk("q", bus.q, m_q);
      chk("r", bus.r, m_r);
      chk("divzero", {31'd0, bus.divzero}, {31'd0, m_dz});
    end
  end

  // call at a negedge; returns at the negedge of the done cycle
  task automatic op(input string name, input logic [31:0] a, input logic [31:0] b, input logic sd,
                    input logic [31:0] eq, input logic [31:0] er, input logic edz, input int rp);
    int k;
    bus.start   = 1'b1;
    bus.a       = a;
    bus.b       = b;
    bus.signdiv = sd;
    k = 0;
    while (k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1 || k == rp + 1) begin
        bus.start   = 1'b0;
        bus.a       = $urandom;
        bus.b       = $urandom;
        bus.signdiv = 1'($urandom_range(0, 1));
      end
      if (rp != 0 && k == rp) begin
        bus.start   = 1'b1;
        bus.a       = 32'd5;
        bus.b       = 32'd5;
        bus.signdiv = 1'b0;
      end
      if (bus.done === 1'b1) break;
    end
    chk({name, "_lat"}, k, 35);
    chk({name, "_q"}, bus.q, eq);
    chk({name, "_r"}, bus.r, er);
    chk({name, "_dz"}, {31'd0, bus.divzero}, {31'd0, edz});
  endtask

  initial begin
    int seen;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.signdiv = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_q", bus.q, 32'd0);
    chk("rst_r", bus.r, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    op("u100_7",  32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, 0);
    @(negedge clk);
    op("s-7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 0);
    op("s7_-2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          1'b0, 0);
    op("s-7_-2",  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  1'b0, 0);
    repeat (3) @(negedge clk);
    op("uff_1",   32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, 0);
    op("sff_1",   32'hFFFF_FFFF,  32'd1,          1'b1, 32'hFFFF_FFFF,  32'd0,          1'b0, 0);
    op("ovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0,          1'b0, 0);
    op("dz_u",    32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678,  1'b1, 0);
    op("dz_s",    32'h8765_4321,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h8765_4321,  1'b1, 0);
    @(negedge clk);
    op("repulse", 32'd1000,       32'd3,          1'b0, 32'd333,        32'd1,          1'b0, 6);
    op("b2b",     32'd9,          32'd4,          1'b0, 32'd2,          32'd1,          1'b0, 0);
    repeat (2) @(negedge clk);

    bus.start = 1'b1;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    bus.signdiv = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    chk("mid_rst_q", bus.q, 32'd0);
    chk("mid_rst_r", bus.r, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0) seen++;
    end
    chk("no_done_after_rst", seen, 0);
    op("s50_-5",  32'd50,         32'hFFFF_FFFB,  1'b1, 32'hFFFF_FFF6,  32'd0,          1'b0, 0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
